// File: rtl/ising_cfg_master_if.sv
// Host command stream plus the core-matrix configuration bus, as seen from
// the initiator (master) and from the host/core side (slave).
interface ising_cfg_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_last;
  logic        wready;
  logic [31:0] wr_addr;
  logic [31:0] wdata;
  logic [31:0] rd_addr;
  logic [31:0] rdata;
  logic [31:0] phase;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, cmd_last, rdata, phase,
    output cmd_ready, wready, wr_addr, wdata, rd_addr
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, cmd_last, rdata, phase,
    input  cmd_ready, wready, wr_addr, wdata, rd_addr
  );
endinterface

// File: rtl/ising_cfg_master.sv
// Configuration-bus initiator: writes each host weight, reads it back to verify,
// then runs the Ising core for a programmed window and captures the phase word.
module ising_cfg_master #(
  parameter int unsigned RD_LAT      = 2,
  parameter logic [31:0] VERIFY_MASK = 32'hFFFF_FFFF,
  parameter int unsigned ERR_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  ising_cfg_master_if.master bus,
  input  logic [31:0]        run_cycles,
  input  logic [31:0]        phase_addr,
  input  logic               abort,
  input  logic               done_ack,
  output logic               ising_rstn,
  output logic               axi_rstn,
  output logic [31:0]        phase_out,
  output logic               done,
  output logic               err,
  output logic [ERR_W-1:0]   err_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_WAIT  = 3'd2,
    CHECK    = 3'd3,
    RUN      = 3'd4,
    CAP_WAIT = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [31:0]      RD_LAT_C = 32'(RD_LAT);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_t      state_r;
  logic [31:0] cnt_r;
  logic        last_r;

  function automatic logic verify_mismatch(input logic [31:0] rd, input logic [31:0] wr);
    return ((rd ^ wr) & VERIFY_MASK) != 32'd0;
  endfunction

  // Config-logic reset release: follows rst deassertion by one clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_rstn <= 1'b0;
    end else begin
      axi_rstn <= 1'b1;
    end
  end

  // Sequencer FSM with all bus and status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 32'd0;
      last_r        <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.wready    <= 1'b0;
      bus.wr_addr   <= 32'd0;
      bus.wdata     <= 32'd0;
      bus.rd_addr   <= 32'd0;
      ising_rstn    <= 1'b0;
      phase_out     <= 32'd0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_count     <= {ERR_W{1'b0}};
    end else if (abort) begin
      // Abort keeps the error history and the last captured phase.
      state_r       <= IDLE;
      bus.cmd_ready <= 1'b1;
      bus.wready    <= 1'b0;
      ising_rstn    <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.wr_addr   <= bus.cmd_addr;
            bus.wdata     <= bus.cmd_data;
            last_r        <= bus.cmd_last;
            bus.wready    <= 1'b1;
            bus.cmd_ready <= 1'b0;
            state_r       <= WRITE;
          end
        end
        WRITE: begin
          bus.wready  <= 1'b0;
          bus.rd_addr <= bus.wr_addr;
          cnt_r       <= RD_LAT_C;
          state_r     <= RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt_r == 32'd1) begin
            state_r <= CHECK;
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end
        CHECK: begin
          if (verify_mismatch(bus.rdata, bus.wdata)) begin
            err <= 1'b1;
            if (err_count != ERR_MAX) begin
              err_count <= err_count + ERR_W'(1);
            end
          end
          if (last_r) begin
            // A zero-length window still runs the core for one cycle.
            cnt_r      <= (run_cycles == 32'd0) ? 32'd1 : run_cycles;
            ising_rstn <= 1'b1;
            state_r    <= RUN;
          end else begin
            bus.cmd_ready <= 1'b1;
            state_r       <= IDLE;
          end
        end
        RUN: begin
          if (cnt_r == 32'd1) begin
            bus.rd_addr <= phase_addr;
            cnt_r       <= RD_LAT_C;
            state_r     <= CAP_WAIT;
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end
        CAP_WAIT: begin
          if (cnt_r == 32'd1) begin
            phase_out  <= bus.phase;
            ising_rstn <= 1'b0;
            done       <= 1'b1;
            state_r    <= DONE;
          end else begin
            cnt_r <= cnt_r - 32'd1;
          end
        end
        DONE: begin
          if (done_ack) begin
            done          <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state_r       <= IDLE;
          end
        end
        default: begin
          state_r       <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.wready    <= 1'b0;
          ising_rstn    <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ising_cfg_master.sv
// Directed bench: dut_a verifies bit 0 with a 2-bit error counter, dut_b verifies
// bit 1 with the default counter; both see the same stimulus.
module tb_ising_cfg_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_last, abort, done_ack;
  logic [31:0] cmd_addr, cmd_data, rdata, phase, run_cycles, phase_addr;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ising_cfg_master_if bus_a();
  ising_cfg_master_if bus_b();

  assign bus_a.cmd_valid = cmd_valid;
  assign bus_a.cmd_addr  = cmd_addr;
  assign bus_a.cmd_data  = cmd_data;
  assign bus_a.cmd_last  = cmd_last;
  assign bus_a.rdata     = rdata;
  assign bus_a.phase     = phase;
  assign bus_b.cmd_valid = cmd_valid;
  assign bus_b.cmd_addr  = cmd_addr;
  assign bus_b.cmd_data  = cmd_data;
  assign bus_b.cmd_last  = cmd_last;
  assign bus_b.rdata     = rdata;
  assign bus_b.phase     = phase;

  logic        ising_rstn_a, axi_rstn_a, done_a, err_a;
  logic [31:0] phase_out_a;
  logic [1:0]  err_count_a;
  logic        ising_rstn_b, axi_rstn_b, done_b, err_b;
  logic [31:0] phase_out_b;
  logic [15:0] err_count_b;

  ising_cfg_master #(.RD_LAT(2), .VERIFY_MASK(32'h0000_0001), .ERR_W(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .run_cycles(run_cycles), .phase_addr(phase_addr),
    .abort(abort), .done_ack(done_ack), .ising_rstn(ising_rstn_a), .axi_rstn(axi_rstn_a),
    .phase_out(phase_out_a), .done(done_a), .err(err_a), .err_count(err_count_a)
  );

  ising_cfg_master #(.RD_LAT(2), .VERIFY_MASK(32'h0000_0002), .ERR_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .run_cycles(run_cycles), .phase_addr(phase_addr),
    .abort(abort), .done_ack(done_ack), .ising_rstn(ising_rstn_b), .axi_rstn(axi_rstn_b),
    .phase_out(phase_out_b), .done(done_b), .err(err_b), .err_count(err_count_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command while the master is idle and step past the accepting edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] d, input logic l);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_last  = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus_a.cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Count edges after which ising_rstn is high, until done rises.
  task automatic wait_done(output int hi);
    int n;
    n  = 0;
    hi = 0;
    while (done_a !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (ising_rstn_a === 1'b1) hi++;
    end
  endtask

  initial begin
    int n;
    int hi;
    rst = 1'b1; cmd_valid = 1'b0; cmd_last = 1'b0; abort = 1'b0; done_ack = 1'b0;
    cmd_addr = 32'd0; cmd_data = 32'd0; rdata = 32'd0; phase = 32'd0;
    run_cycles = 32'd0; phase_addr = 32'h0000_0100;

    // T1: reset values, release, and asynchronous reset mid-WRITE
    tick(); tick();
    check_eq("rst_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
    check_eq("rst_wready", 32'(bus_a.wready), 32'd0);
    check_eq("rst_ising_rstn", 32'(ising_rstn_a), 32'd0);
    check_eq("rst_axi_rstn", 32'(axi_rstn_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_err_count", 32'(err_count_a), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("axi_rstn_release", 32'(axi_rstn_a), 32'd1);
    rdata = 32'd3;
    accept(32'd1, 32'd3, 1'b0);
    check_eq("t1_wready_pulse", 32'(bus_a.wready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t1_async_wready", 32'(bus_a.wready), 32'd0);
    check_eq("t1_async_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
    check_eq("t1_async_axi_rstn", 32'(axi_rstn_a), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("t1_axi_before_edge", 32'(axi_rstn_a), 32'd0);
    tick();
    check_eq("t1_axi_after_edge", 32'(axi_rstn_a), 32'd1);

    // T2: single write with echoing readback
    rdata = 32'd3;
    accept(32'd5, 32'd3, 1'b0);
    check_eq("t2_wready", 32'(bus_a.wready), 32'd1);
    check_eq("t2_wr_addr", bus_a.wr_addr, 32'd5);
    check_eq("t2_wdata", bus_a.wdata, 32'd3);
    check_eq("t2_cmd_ready_low", 32'(bus_a.cmd_ready), 32'd0);
    tick();
    check_eq("t2_wready_single", 32'(bus_a.wready), 32'd0);
    check_eq("t2_rd_addr", bus_a.rd_addr, 32'd5);
    check_eq("t2_wdata_hold", bus_a.wdata, 32'd3);
    wait_ready(n);
    // Ready returns RD_LAT+2 edges after the accepting edge (RD_LAT+3 cycles from handshake).
    check_eq("t2_ready_latency", 32'(n + 1), 32'd4);
    check_eq("t2_err", 32'(err_a), 32'd0);

    // T3: rdata 0x2 vs wdata 0x3 -> bit 0 differs, bit 1 agrees
    rdata = 32'd2;
    accept(32'd6, 32'd3, 1'b0);
    wait_ready(n);
    check_eq("t3_ready_latency", 32'(n), 32'd4);
    check_eq("t3_err_a", 32'(err_a), 32'd1);
    check_eq("t3_count_a", 32'(err_count_a), 32'd1);
    check_eq("t3_err_b_masked", 32'(err_b), 32'd0);

    // T4: four more mismatches -> 2-bit counter saturates at 3
    for (int k = 2; k <= 5; k++) begin
      accept(32'(k + 10), 32'd3, 1'b0);
      wait_ready(n);
      check_eq($sformatf("t4_count_%0d", k), 32'(err_count_a), (k < 3) ? 32'(k) : 32'd3);
    end
    check_eq("t4_err_b_masked", 32'(err_b), 32'd0);
    check_eq("t4_count_b", 32'(err_count_b), 32'd0);

    // T5: run window of 10 cycles, then capture phase
    rdata = 32'd7; run_cycles = 32'd10; phase = 32'h0000_00A5;
    accept(32'd7, 32'd7, 1'b1);
    wait_done(hi);
    check_eq("t5_done", 32'(done_a), 32'd1);
    check_eq("t5_rstn_window", 32'(hi), 32'd12);
    check_eq("t5_rstn_low_in_done", 32'(ising_rstn_a), 32'd0);
    check_eq("t5_phase_out", phase_out_a, 32'h0000_00A5);
    check_eq("t5_rd_addr_phase", bus_a.rd_addr, 32'h0000_0100);
    tick(); tick();
    check_eq("t5_done_held", 32'(done_a), 32'd1);
    check_eq("t5_cmd_ready_in_done", 32'(bus_a.cmd_ready), 32'd0);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check_eq("t5_done_ack", 32'(done_a), 32'd0);
    check_eq("t5_ready_after_ack", 32'(bus_a.cmd_ready), 32'd1);

    // T5b: run_cycles=0 behaves as 1
    run_cycles = 32'd0; phase = 32'h0000_005A;
    accept(32'd8, 32'd7, 1'b1);
    check_eq("t5b_phase_held", phase_out_a, 32'h0000_00A5);
    wait_done(hi);
    check_eq("t5b_done", 32'(done_a), 32'd1);
    check_eq("t5b_rstn_window", 32'(hi), 32'd3);
    check_eq("t5b_phase_out", phase_out_a, 32'h0000_005A);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;

    // T6: abort during RUN
    run_cycles = 32'd20;
    accept(32'd9, 32'd7, 1'b1);
    for (int k = 0; k < 6; k++) tick();
    check_eq("t6_in_run", 32'(ising_rstn_a), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t6_abort_rstn", 32'(ising_rstn_a), 32'd0);
    check_eq("t6_abort_ready", 32'(bus_a.cmd_ready), 32'd1);
    check_eq("t6_abort_done", 32'(done_a), 32'd0);
    check_eq("t6_err_kept", 32'(err_a), 32'd1);
    check_eq("t6_count_kept", 32'(err_count_a), 32'd3);
    check_eq("t6_phase_kept", phase_out_a, 32'h0000_005A);

    // abort beats command acceptance in IDLE
    cmd_valid = 1'b1; abort = 1'b1;
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
    check_eq("t6_abort_vs_cmd_wready", 32'(bus_a.wready), 32'd0);
    check_eq("t6_abort_vs_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);

    // abort together with done_ack in DONE
    run_cycles = 32'd1;
    accept(32'd10, 32'd7, 1'b1);
    wait_done(hi);
    check_eq("t6_reach_done", 32'(done_a), 32'd1);
    abort = 1'b1; done_ack = 1'b1;
    tick();
    abort = 1'b0; done_ack = 1'b0;
    check_eq("t6_abort_ack_done", 32'(done_a), 32'd0);
    check_eq("t6_abort_ack_rstn", 32'(ising_rstn_a), 32'd0);
    check_eq("t6_abort_ack_ready", 32'(bus_a.cmd_ready), 32'd1);
    check_eq("t6_abort_ack_err", 32'(err_a), 32'd1);

    // bit-1 mismatch: seen only by the bit-1 mask
    rdata = 32'd1;
    accept(32'd11, 32'd3, 1'b0);
    wait_ready(n);
    check_eq("mask2_ready", 32'(n), 32'd4);
    check_eq("mask2_err_b", 32'(err_b), 32'd1);
    check_eq("mask2_count_b", 32'(err_count_b), 32'd1);
    check_eq("mask2_count_a", 32'(err_count_a), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
